// File: rtl/reg8_wr_arbiter_if.sv
// Write-request bus between two requesters (A, B) and the reg8 write arbiter,
// plus the EN/D drive toward the register bank.
interface reg8_wr_arbiter_if #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
);
  logic              req_a;
  logic [ADDR_W-1:0] addr_a;
  logic [7:0]        data_a;
  logic              req_b;
  logic [ADDR_W-1:0] addr_b;
  logic [7:0]        data_b;
  logic              hold;
  logic [NUM_REGS-1:0] en;
  logic [7:0]        d_out;
  logic              ack_a;
  logic              ack_b;
  logic              busy;

  modport master (
    output req_a, addr_a, data_a, req_b, addr_b, data_b, hold,
    input  en, d_out, ack_a, ack_b, busy
  );

  modport slave (
    input  req_a, addr_a, data_a, req_b, addr_b, data_b, hold,
    output en, d_out, ack_a, ack_b, busy
  );
endinterface

// File: rtl/reg8_wr_arbiter.sv
// Round-robin write arbiter: two requesters share one EN/D port into a bank of
// NUM_REGS 8-bit registers; each write is a single registered EN cycle.
module reg8_wr_arbiter #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input logic              clk,
  input logic              rst,
  reg8_wr_arbiter_if.slave bus
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_req_t;

  logic [0:0]          state;
  logic                last_b;
  logic                win_b;
  logic                any_req;
  logic                pick_b;
  wr_req_t             sel;
  logic [NUM_REGS-1:0] sel_en;

  // On contention the requester that did not win last time takes the grant.
  always_comb begin
    any_req = bus.req_a | bus.req_b;
    pick_b  = bus.req_b & (~bus.req_a | ~last_b);
    sel     = pick_b ? wr_req_t'{bus.addr_b, bus.data_b}
                     : wr_req_t'{bus.addr_a, bus.data_a};
    sel_en  = '0;
    // Out-of-range addresses match no bit, so the write is acked but dropped.
    for (int i = 0; i < NUM_REGS; i++)
      if (sel.addr == ADDR_W'(i)) sel_en[i] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      last_b    <= 1'b1;
      win_b     <= 1'b0;
      bus.en    <= '0;
      bus.d_out <= 8'h00;
      bus.ack_a <= 1'b0;
      bus.ack_b <= 1'b0;
      bus.busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!bus.hold && any_req) begin
            state     <= S_WRITE;
            win_b     <= pick_b;
            bus.en    <= sel_en;
            bus.d_out <= sel.data;
            bus.ack_a <= ~pick_b;
            bus.ack_b <= pick_b;
            bus.busy  <= 1'b1;
          end
        end
        default: begin
          // d_out keeps the last written value through IDLE.
          state     <= S_IDLE;
          last_b    <= win_b;
          bus.en    <= '0;
          bus.ack_a <= 1'b0;
          bus.ack_b <= 1'b0;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
